// File: rtl/zbuf_depth_tester.sv
// Depth test and commit for the rasterizer pixel stream, plus the
// z-buffer / frame-buffer clear sweep.
module zbuf_depth_tester #(
  parameter int unsigned FB_HRES          = 320,
  parameter int unsigned FB_VRES          = 180,
  parameter int unsigned ZWIDTH           = 16,
  parameter int unsigned COLOR_WIDTH      = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  parameter int unsigned PIXEL_ADDR_WIDTH = $clog2(FB_HRES * FB_VRES)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [PIXEL_ADDR_WIDTH-1:0] addr_in,
  input  logic [ZWIDTH-1:0]           z_in,
  input  logic [COLOR_WIDTH-1:0]      color_in,
  input  logic                        last_pixel_in,
  input  logic                        clear_in,
  output logic [PIXEL_ADDR_WIDTH-1:0] zb_raddr_out,
  input  logic [ZWIDTH-1:0]           zb_rdata_in,
  output logic                        zb_we_out,
  output logic [PIXEL_ADDR_WIDTH-1:0] zb_waddr_out,
  output logic [ZWIDTH-1:0]           zb_wdata_out,
  output logic                        fb_we_out,
  output logic [PIXEL_ADDR_WIDTH-1:0] fb_addr_out,
  output logic [COLOR_WIDTH-1:0]      fb_data_out,
  output logic                        tri_done_out,
  output logic                        clear_done_out,
  output logic                        busy_out
);

  localparam int unsigned NPIX = FB_HRES * FB_VRES;
  localparam logic [PIXEL_ADDR_WIDTH-1:0] LAST_ADDR = PIXEL_ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t                      state_q;
  logic                        s1_valid_q, s2_valid_q, s3_valid_q;
  logic [PIXEL_ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q;
  logic [ZWIDTH-1:0]           s1_z_q, s2_z_q;
  logic [COLOR_WIDTH-1:0]      s1_color_q, s2_color_q;
  logic                        s1_last_q, s2_last_q;
  logic                        we_q, tri_done_q, clear_done_q;
  logic [PIXEL_ADDR_WIDTH-1:0] wr_addr_q, clr_cnt_q;
  logic [ZWIDTH-1:0]           wr_z_q;
  logic [COLOR_WIDTH-1:0]      wr_color_q;

  logic hazard_c, accept_c, stages_busy_c, pass_c;

  // Read-first BRAM: block any pixel whose address is still in flight,
  // including the S3 write cycle.
  assign hazard_c = (s1_valid_q && (s1_addr_q == addr_in)) ||
                    (s2_valid_q && (s2_addr_q == addr_in)) ||
                    (s3_valid_q && (wr_addr_q == addr_in));
  assign stages_busy_c = s1_valid_q || s2_valid_q || s3_valid_q;
  assign ready_out     = !rst_in && (state_q == RUN) && !hazard_c;
  assign accept_c      = valid_in && ready_out;
  assign pass_c        = s2_z_q < zb_rdata_in;

  assign zb_raddr_out   = addr_in;
  assign zb_we_out      = we_q;
  assign zb_waddr_out   = wr_addr_q;
  assign zb_wdata_out   = wr_z_q;
  assign fb_we_out      = we_q;
  assign fb_addr_out    = wr_addr_q;
  assign fb_data_out    = wr_color_q;
  assign tri_done_out   = tri_done_q;
  assign clear_done_out = clear_done_q;
  assign busy_out       = stages_busy_c || (state_q != RUN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= RUN;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s3_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s2_addr_q    <= '0;
      s1_z_q       <= '0;
      s2_z_q       <= '0;
      s1_color_q   <= '0;
      s2_color_q   <= '0;
      s1_last_q    <= 1'b0;
      s2_last_q    <= 1'b0;
      we_q         <= 1'b0;
      tri_done_q   <= 1'b0;
      clear_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_z_q       <= '0;
      wr_color_q   <= '0;
      clr_cnt_q    <= '0;
    end else begin
      // S1/S2 cover the BRAM read latency; S3 is the write register.
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_addr_q  <= addr_in;
        s1_z_q     <= z_in;
        s1_color_q <= color_in;
        s1_last_q  <= last_pixel_in;
      end
      s2_valid_q   <= s1_valid_q;
      s2_addr_q    <= s1_addr_q;
      s2_z_q       <= s1_z_q;
      s2_color_q   <= s1_color_q;
      s2_last_q    <= s1_last_q;
      s3_valid_q   <= s2_valid_q;
      tri_done_q   <= s2_valid_q && s2_last_q;
      clear_done_q <= 1'b0;
      we_q         <= 1'b0;

      if (state_q == CLEAR) begin
        we_q       <= 1'b1;
        wr_addr_q  <= clr_cnt_q;
        wr_z_q     <= '1;
        wr_color_q <= CLEAR_COLOR;
        clr_cnt_q  <= clr_cnt_q + PIXEL_ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          clear_done_q <= 1'b1;
          clr_cnt_q    <= '0;
          state_q      <= RUN;
        end
      end else if (s2_valid_q) begin
        we_q       <= pass_c;
        wr_addr_q  <= s2_addr_q;
        wr_z_q     <= s2_z_q;
        wr_color_q <= s2_color_q;
      end

      case (state_q)
        RUN:     if (clear_in) state_q <= (stages_busy_c || accept_c) ? DRAIN : CLEAR;
        DRAIN:   if (!stages_busy_c) state_q <= CLEAR;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zbuf_depth_tester.sv
// Scoreboard bench for zbuf_depth_tester: depth-map reference model at
// acceptance time, BRAM environment model, and a negedge output monitor.
module tb_zbuf_depth_tester;

  localparam int NPIX = 320 * 180;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [15:0] addr_in = '0;
  logic [15:0] z_in = '0;
  logic [15:0] color_in = '0;
  logic        last_pixel_in = 1'b0;
  logic        clear_in = 1'b0;
  logic [15:0] zb_raddr_out;
  logic [15:0] zb_rdata_in = '0;
  logic        zb_we_out;
  logic [15:0] zb_waddr_out;
  logic [15:0] zb_wdata_out;
  logic        fb_we_out;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        tri_done_out;
  logic        clear_done_out;
  logic        busy_out;

  zbuf_depth_tester dut (
    .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
    .addr_in(addr_in), .z_in(z_in), .color_in(color_in),
    .last_pixel_in(last_pixel_in), .clear_in(clear_in),
    .zb_raddr_out(zb_raddr_out), .zb_rdata_in(zb_rdata_in),
    .zb_we_out(zb_we_out), .zb_waddr_out(zb_waddr_out), .zb_wdata_out(zb_wdata_out),
    .fb_we_out(fb_we_out), .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out),
    .tri_done_out(tri_done_out), .clear_done_out(clear_done_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit we;
    int addr;
    int z;
    int c;
    bit last;
  } exp_t;

  exp_t expq[$];
  int   ref_z [NPIX];
  logic [15:0] mem [NPIX];
  logic [15:0] rd1 = '0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   clr_req = 0;
  int   clr_req_seen = 0;
  bit   clr_active = 1'b0;
  int   clr_next = 0;
  bit   clr_seen_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first dual-port z-buffer with 2-cycle read latency.
  always @(posedge clk) begin
    rd1         <= mem[zb_raddr_out];
    zb_rdata_in <= rd1;
    if (zb_we_out) mem[zb_waddr_out] <= zb_wdata_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pixel retirements in due order, then clear sweep, else quiet.
  exp_t m;
  always @(negedge clk) begin
    if (clr_req != clr_req_seen) begin
      clr_req_seen  = clr_req;
      clr_active    = 1'b1;
      clr_next      = 0;
      clr_seen_done = 1'b0;
    end
    chk("fb_zb_we_match", 32'(fb_we_out), 32'(zb_we_out));
    if (expq.size() > 0 && expq[0].due == cyc) begin
      m = expq.pop_front();
      chk("px_we", 32'(zb_we_out), 32'(m.we));
      chk("px_tri_done", 32'(tri_done_out), 32'(m.last));
      chk("px_clear_done", 32'(clear_done_out), 0);
      if (m.we) begin
        chk("px_zb_addr", 32'(zb_waddr_out), 32'(m.addr));
        chk("px_fb_addr", 32'(fb_addr_out), 32'(m.addr));
        chk("px_zb_data", 32'(zb_wdata_out), 32'(m.z));
        chk("px_fb_data", 32'(fb_data_out), 32'(m.c));
      end
    end else if (clr_active && zb_we_out) begin
      chk("clr_zb_addr", 32'(zb_waddr_out), 32'(clr_next));
      chk("clr_fb_addr", 32'(fb_addr_out), 32'(clr_next));
      chk("clr_zb_data", 32'(zb_wdata_out), 32'hFFFF);
      chk("clr_fb_data", 32'(fb_data_out), 32'h0);
      chk("clr_done_pulse", 32'(clear_done_out), 32'(clr_next == NPIX - 1));
      clr_next++;
      if (clr_next == NPIX) begin
        clr_active    = 1'b0;
        clr_seen_done = 1'b1;
      end
    end else if (clr_active && clr_next > 0) begin
      chk("clr_gap_we", 32'(zb_we_out), 1);
    end else begin
      chk("idle_we", 32'(zb_we_out), 0);
      chk("idle_tri_done", 32'(tri_done_out), 0);
      chk("idle_clear_done", 32'(clear_done_out), 0);
    end
    // The coming edge resets the DUT: nothing in flight may retire.
    if (rst_in) begin
      expq.delete();
      clr_active = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input int a, input int z, input int c, input bit last, output int waits);
    exp_t e;
    bit done;
    valid_in = 1'b1;
    addr_in = 16'(a);
    z_in = 16'(z);
    color_in = 16'(c);
    last_pixel_in = last;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      #1;
      if (ready_out) begin
        chk("raddr", 32'(zb_raddr_out), 32'(a));
        e.due = cyc + 3; e.we = (z < ref_z[a]); e.addr = a; e.z = z; e.c = c; e.last = last;
        if (e.we) ref_z[a] = z;
        expq.push_back(e);
        done = 1'b1;
      end
      step();
      if (!done) begin
        waits++;
        if (waits > 20) begin
          chk("send_timeout_ready", 32'(ready_out), 1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, sum;
    int g;
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = 16'hFFFF;
      ref_z[i] = 32'hFFFF;
    end

    // Reset values
    repeat (3) step();
    chk("rst_ready", 32'(ready_out), 0);
    chk("rst_zb_we", 32'(zb_we_out), 0);
    chk("rst_fb_we", 32'(fb_we_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_tri_done", 32'(tri_done_out), 0);
    chk("rst_clear_done", 32'(clear_done_out), 0);
    chk("rst_waddr", 32'(zb_waddr_out), 0);
    chk("rst_fb_data", 32'(fb_data_out), 0);
    rst_in = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready_out), 1);
    step();

    // Empty buffer write with last pixel
    send(5, 16'h1000, 16'hABCD, 1'b1, w);
    idle(4);

    // Strict depth test at addr 7
    send(7, 16'h0800, 16'h1111, 1'b0, w);
    send(7, 16'h0900, 16'h2222, 1'b0, w);
    chk("stall_addr7_a", 32'(w), 3);
    send(7, 16'h0800, 16'h3333, 1'b1, w);
    chk("stall_addr7_b", 32'(w), 3);
    send(7, 16'h07FF, 16'h4444, 1'b0, w);
    idle(4);

    // Back-to-back same address
    send(10, 16'h2000, 16'h5555, 1'b0, w);
    send(10, 16'h1000, 16'h6666, 1'b0, w);
    chk("stall_addr10", 32'(w), 3);
    idle(4);

    // Full-rate stream of distinct addresses
    sum = 0;
    for (int i = 0; i < 100; i++) begin
      send(i, i, 16'h8000 + i, (i == 99), w);
      sum += w;
    end
    chk("stream_no_stall", 32'(sum), 0);
    idle(4);

    // Randomized traffic over a small window to provoke hazards
    for (int i = 0; i < 300; i++) begin
      send(200 + int'($urandom_range(0, 31)), int'($urandom_range(0, 16'hFFFE)),
           int'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 7) == 0), w);
      if (w > 3) chk("rand_stall_bound", 32'(w), 3);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(5);
    chk("busy_idle", 32'(busy_out), 0);

    // Clear with two pixels in flight; second arrives with clear_in
    send(400, 16'h0100, 16'h0A0A, 1'b0, w);
    clear_in = 1'b1;
    send(401, 16'h0200, 16'h0B0B, 1'b1, w);
    clear_in = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < NPIX; i++) ref_z[i] = 32'hFFFF;
    clr_req++;
    g = 0;
    while (!clr_seen_done && g < NPIX + 50) begin
      step();
      g++;
      if (g == 100) begin
        chk("clear_ready_low", 32'(ready_out), 0);
        chk("clear_busy", 32'(busy_out), 1);
      end
    end
    chk("clear_completed", 32'(clr_seen_done), 1);
    chk("post_clear_ready", 32'(ready_out), 1);
    step();
    chk("post_clear_busy", 32'(busy_out), 0);
    send(401, 16'hFFFE, 16'h0C0C, 1'b0, w);
    idle(4);

    // Reset in the middle of a clear sweep
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    clr_req++;
    g = 0;
    while (clr_next < 1000 && g < 2000) begin
      step();
      g++;
    end
    chk("clear_reached_1000", 32'(clr_next >= 1000), 1);
    rst_in = 1'b1;
    step();
    chk("rst_mid_clear_we", 32'(zb_we_out), 0);
    chk("rst_mid_clear_busy", 32'(busy_out), 0);
    chk("rst_mid_clear_ready", 32'(ready_out), 0);
    step();
    rst_in = 1'b0;
    #1;
    chk("after_rst_ready", 32'(ready_out), 1);
    step();
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(0, NPIX - 1)), int'($urandom_range(0, 16'hFFFE)),
           int'($urandom_range(0, 16'hFFFF)), 1'b1, w);
    idle(6);
    chk("queue_drained", 32'(expq.size()), 0);
    chk("final_busy", 32'(busy_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
